// File: rtl/sr_mem_ctrl.sv
// rtl/sr_mem_ctrl.sv - per-core data-memory controller: local word RAM plus external valid/ready port
// Level-held core requests are accepted only in IDLE and answered with a single completion pulse.
module sr_mem_ctrl #(
  parameter int          LOCAL_WORDS  = 1024,
  parameter int          READ_LATENCY = 1,
  parameter logic [2:0]  OP_LOAD      = 3'd1,
  parameter logic [2:0]  OP_STORE     = 3'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  cpu_instr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_data_received,
  output logic        cpu_instr_taken,
  output logic        ext_req_valid,
  output logic        ext_req_we,
  output logic [31:0] ext_req_addr,
  output logic [31:0] ext_req_wdata,
  input  logic        ext_req_ready,
  input  logic        ext_resp_valid,
  input  logic [31:0] ext_resp_data
);

  localparam int         AW          = (LOCAL_WORDS > 1) ? $clog2(LOCAL_WORDS) : 1;
  localparam logic [31:0] LOCAL_LIMIT = 32'(LOCAL_WORDS);
  localparam logic [2:0]  LAT_LAST    = 3'(READ_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, LRD, XREQ, XWAIT, RESP} state_t;

  state_t      state;
  logic [31:0] ram [LOCAL_WORDS];
  logic [31:0] ramQ;
  logic [2:0]  lrdCnt;
  logic        isLoad, isStore, isLocal, accept, ramWe, ramRe;
  logic [AW-1:0] ramIdx;
  logic        unusedAddrLsb;

  assign isLoad        = (cpu_instr == OP_LOAD);
  assign isStore       = (cpu_instr == OP_STORE);
  assign isLocal       = ({2'b00, cpu_addr[31:2]} < LOCAL_LIMIT);
  assign ramIdx        = cpu_addr[AW+1:2];
  assign accept        = (state == IDLE) && (isLoad || isStore);
  // Gated by rst_n so a request held during reset cannot touch the RAM.
  assign ramWe         = rst_n && accept && isStore && isLocal;
  assign ramRe         = rst_n && accept && isLoad && isLocal;
  assign unusedAddrLsb = ^cpu_addr[1:0];

  // RAM is not reset; the read word stays in ramQ because nothing writes while a load waits in LRD.
  always_ff @(posedge clk) begin
    if (ramWe) ram[ramIdx] <= cpu_wdata;
    if (ramRe) ramQ <= ram[ramIdx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      lrdCnt            <= 3'd0;
      cpu_rdata         <= 32'd0;
      cpu_data_received <= 1'b0;
      cpu_instr_taken   <= 1'b0;
      ext_req_valid     <= 1'b0;
      ext_req_we        <= 1'b0;
      ext_req_addr      <= 32'd0;
      ext_req_wdata     <= 32'd0;
    end else begin
      cpu_data_received <= 1'b0;
      cpu_instr_taken   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (isLocal && isStore) begin
              state           <= RESP;
              cpu_instr_taken <= 1'b1;
            end else if (isLocal) begin
              state  <= LRD;
              lrdCnt <= LAT_LAST;
            end else begin
              state         <= XREQ;
              ext_req_valid <= 1'b1;
              ext_req_we    <= isStore;
              ext_req_addr  <= cpu_addr;
              ext_req_wdata <= cpu_wdata;
            end
          end
        end
        LRD: begin
          if (lrdCnt == 3'd0) begin
            state             <= RESP;
            cpu_rdata         <= ramQ;
            cpu_data_received <= 1'b1;
          end else begin
            lrdCnt <= lrdCnt - 3'd1;
          end
        end
        XREQ: begin
          if (ext_req_ready) begin
            ext_req_valid <= 1'b0;
            if (ext_req_we) begin
              state           <= RESP;
              cpu_instr_taken <= 1'b1;
            end else begin
              state <= XWAIT;
            end
          end
        end
        XWAIT: begin
          if (ext_resp_valid) begin
            state             <= RESP;
            cpu_rdata         <= ext_resp_data;
            cpu_data_received <= 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_mem_ctrl.sv
// tb/tb_sr_mem_ctrl.sv - scoreboard bench for sr_mem_ctrl (READ_LATENCY 1 and 3 instances)
// The driver predicts each pulse cycle from the timing rules; a negedge monitor pops and compares.
module tb_sr_mem_ctrl;

  localparam int         LW     = 1024;
  localparam logic [2:0] OP_LD  = 3'd1;
  localparam logic [2:0] OP_ST  = 3'd2;

  typedef struct { bit isLoad; logic [31:0] data; int cyc; } sbEnt_t;
  typedef struct { logic [31:0] addr; logic [31:0] wdata; bit we; int first; int last; } xEnt_t;

  logic        clk = 1'b0;
  logic        rstN [2];
  logic [2:0]  cpuInstr [2];
  logic [31:0] cpuAddr [2];
  logic [31:0] cpuWdata [2];
  logic [31:0] rdata [2];
  logic        dataRcv [2];
  logic        instrTk [2];
  logic        extValid [2];
  logic        extWe [2];
  logic [31:0] extAddr [2];
  logic [31:0] extWdata [2];
  logic        extReady [2];
  logic        extRespValid [2];
  logic [31:0] extRespData [2];

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          done = 0;
  bit          finalDone = 0;
  sbEnt_t      sbQ [2][$];
  xEnt_t       extQ [2][$];
  logic [31:0] expRdata [2];
  logic [31:0] mem [2][LW];
  sbEnt_t      mE;
  xEnt_t       mX;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sr_mem_ctrl #(.LOCAL_WORDS(LW), .READ_LATENCY(1), .OP_LOAD(OP_LD), .OP_STORE(OP_ST)) u0 (
    .clk(clk), .rst_n(rstN[0]), .cpu_instr(cpuInstr[0]), .cpu_addr(cpuAddr[0]), .cpu_wdata(cpuWdata[0]),
    .cpu_rdata(rdata[0]), .cpu_data_received(dataRcv[0]), .cpu_instr_taken(instrTk[0]),
    .ext_req_valid(extValid[0]), .ext_req_we(extWe[0]), .ext_req_addr(extAddr[0]), .ext_req_wdata(extWdata[0]),
    .ext_req_ready(extReady[0]), .ext_resp_valid(extRespValid[0]), .ext_resp_data(extRespData[0]));

  sr_mem_ctrl #(.LOCAL_WORDS(LW), .READ_LATENCY(3), .OP_LOAD(OP_LD), .OP_STORE(OP_ST)) u1 (
    .clk(clk), .rst_n(rstN[1]), .cpu_instr(cpuInstr[1]), .cpu_addr(cpuAddr[1]), .cpu_wdata(cpuWdata[1]),
    .cpu_rdata(rdata[1]), .cpu_data_received(dataRcv[1]), .cpu_instr_taken(instrTk[1]),
    .ext_req_valid(extValid[1]), .ext_req_we(extWe[1]), .ext_req_addr(extAddr[1]), .ext_req_wdata(extWdata[1]),
    .ext_req_ready(extReady[1]), .ext_resp_valid(extRespValid[1]), .ext_resp_data(extRespData[1]));

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d, input int k);
    int c;
    for (int i = 0; i < k; i++) begin
      c = $urandom_range(0, 5);
      cpuInstr[d]     = (c == 5) ? 3'd0 : 3'(c + 3);
      cpuAddr[d]      = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      cpuWdata[d]     = $urandom;
      extReady[d]     = 1'($urandom_range(0, 1));
      extRespValid[d] = 1'($urandom_range(0, 1));
      extRespData[d]  = $urandom;
      step();
    end
  endtask

  // One core request: predict its pulse cycle and data, then hold it until that pulse cycle.
  task automatic doReq(input int d, input logic [2:0] instr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] respData, input int rdyDly, input int respDly, input int abortAfter);
    sbEnt_t e;
    xEnt_t  x;
    int     n, xfer, respCyc, pulse;
    bit     isLd, isLoc, extLd;
    isLd    = (instr == OP_LD);
    isLoc   = (addr[31:2] < 30'(LW));
    extLd   = !isLoc && isLd;
    n       = cyc;
    xfer    = n + 1 + rdyDly;
    respCyc = xfer + respDly;
    if (isLoc) pulse = isLd ? n + 1 + lat(d) : n + 1;
    else       pulse = isLd ? respCyc + 1 : xfer + 1;
    e.isLoad = isLd;
    e.cyc    = pulse;
    e.data   = isLd ? (isLoc ? mem[d][addr[11:2]] : respData) : 32'h0;
    if (!isLd && isLoc) mem[d][addr[11:2]] = wdata;
    if (abortAfter == 0) sbQ[d].push_back(e);
    if (!isLoc) begin
      x.addr = addr; x.wdata = wdata; x.we = !isLd; x.first = n + 1; x.last = xfer;
      extQ[d].push_back(x);
    end
    cpuInstr[d] = instr;
    cpuAddr[d]  = addr;
    cpuWdata[d] = wdata;
    while (cyc <= pulse) begin
      if (abortAfter != 0 && cyc == xfer + abortAfter) begin
        rstN[d] = 1'b0;
        break;
      end
      if (!isLoc && cyc > n && cyc <= xfer) extReady[d] = (cyc == xfer);
      else extReady[d] = 1'($urandom_range(0, 1));
      if (extLd && cyc > xfer && cyc <= respCyc) begin
        extRespValid[d] = (cyc == respCyc);
        extRespData[d]  = respData;
      end else begin
        extRespValid[d] = 1'($urandom_range(0, 1));
        extRespData[d]  = $urandom;
      end
      step();
    end
    cpuInstr[d]     = 3'd0;
    cpuAddr[d]      = $urandom;
    extReady[d]     = 1'b0;
    extRespValid[d] = 1'b0;
  endtask

  function automatic logic [31:0] localAddr();
    int w;
    w = $urandom_range(0, 16);
    if (w == 16) w = LW - 1;
    return (32'(w) << 2) | 32'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] extAddrGen();
    int c;
    c = $urandom_range(0, 2);
    if (c == 0) return 32'(LW * 4) + (32'($urandom_range(0, 1023)) << 2) + 32'($urandom_range(0, 3));
    if (c == 1) return 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
    return $urandom | 32'h8000_0000;
  endfunction

  task automatic randomOps(input int d, input int count);
    int k;
    for (int i = 0; i < count; i++) begin
      k = $urandom_range(0, (d == 0) ? 3 : 1);
      case (k)
        0: doReq(d, OP_ST, localAddr(), $urandom, 32'h0, 0, 0, 0);
        1: doReq(d, OP_LD, localAddr(), $urandom, 32'h0, 0, 0, 0);
        2: doReq(d, OP_ST, extAddrGen(), $urandom, 32'h0, $urandom_range(0, 3), 1, 0);
        default: doReq(d, OP_LD, extAddrGen(), $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 4), 0);
      endcase
      idle(d, $urandom_range(0, 2));
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rstN[d]) begin
        vectors++;
        if (extValid[d] || rdata[d] != 32'd0 || dataRcv[d] || instrTk[d]) begin
          miscompares++;
          $display("FAIL reset_outputs dut%0d: valid=%0b rdata=%h rcv=%0b taken=%0b, required all zero",
                   d, extValid[d], rdata[d], dataRcv[d], instrTk[d]);
        end
        expRdata[d] = 32'd0;
      end else begin
        if (dataRcv[d] || instrTk[d]) begin
          vectors++;
          if (sbQ[d].size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_pulse dut%0d cyc %0d: rcv=%0b taken=%0b, required no pulse",
                     d, cyc, dataRcv[d], instrTk[d]);
          end else begin
            mE = sbQ[d].pop_front();
            if ((dataRcv[d] && instrTk[d]) || dataRcv[d] != mE.isLoad || cyc != mE.cyc) begin
              miscompares++;
              $display("FAIL pulse dut%0d: cyc=%0d rcv=%0b taken=%0b, required cyc=%0d load=%0b",
                       d, cyc, dataRcv[d], instrTk[d], mE.cyc, mE.isLoad);
            end
            if (mE.isLoad) begin
              if (rdata[d] !== mE.data) begin
                miscompares++;
                $display("FAIL load_data dut%0d: rdata=%h, required %h", d, rdata[d], mE.data);
              end
              expRdata[d] = mE.data;
            end
          end
        end else if (sbQ[d].size() > 0 && cyc > sbQ[d][0].cyc) begin
          vectors++;
          miscompares++;
          $display("FAIL missing_pulse dut%0d: none by cyc %0d, required at cyc %0d", d, cyc, sbQ[d][0].cyc);
          void'(sbQ[d].pop_front());
        end
        if (!dataRcv[d]) begin
          vectors++;
          if (rdata[d] !== expRdata[d]) begin
            miscompares++;
            $display("FAIL rdata_hold dut%0d cyc %0d: rdata=%h, required %h", d, cyc, rdata[d], expRdata[d]);
          end
        end
        if (extQ[d].size() > 0 && cyc >= extQ[d][0].first) begin
          vectors++;
          mX = extQ[d][0];
          if (!extValid[d] || extAddr[d] != mX.addr || extWe[d] != mX.we || (mX.we && extWdata[d] != mX.wdata)) begin
            miscompares++;
            $display("FAIL ext_req dut%0d cyc %0d: valid=%0b we=%0b addr=%h wdata=%h, required 1 %0b %h %h",
                     d, cyc, extValid[d], extWe[d], extAddr[d], extWdata[d], mX.we, mX.addr, mX.wdata);
          end
          if (cyc >= mX.last) void'(extQ[d].pop_front());
        end else if (extValid[d]) begin
          vectors++;
          miscompares++;
          $display("FAIL ext_req_unexpected dut%0d cyc %0d: valid=1, required 0", d, cyc);
        end
      end
    end
    if (done && !finalDone) begin
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (sbQ[d].size() != 0 || extQ[d].size() != 0) begin
          miscompares++;
          $display("FAIL drain dut%0d: %0d pulses and %0d ext requests outstanding, required 0",
                   d, sbQ[d].size(), extQ[d].size());
        end
      end
      finalDone = 1;
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rstN[d] = 1'b1; cpuInstr[d] = 3'd0; cpuAddr[d] = 32'hFFFF_FFFF; cpuWdata[d] = 32'd0;
      extReady[d] = 1'b0; extRespValid[d] = 1'b0; extRespData[d] = 32'd0; expRdata[d] = 32'd0;
    end
    #1;
    rstN[0] = 1'b0;
    rstN[1] = 1'b0;
    repeat (3) step();
    rstN[0] = 1'b1;
    rstN[1] = 1'b1;
    idle(0, 2);

    doReq(0, OP_ST, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    idle(0, 1);
    doReq(0, OP_LD, 32'h10, 32'h0, 32'h0, 0, 0, 0);
    idle(0, 2);
    for (int w = 0; w <= 16; w++) begin
      doReq(0, OP_ST, (w == 16) ? 32'(LW - 1) << 2 : 32'(w) << 2, $urandom, 32'h0, 0, 0, 0);
    end
    doReq(0, OP_ST, 32'(LW * 4), 32'h1234_5678, 32'h0, 3, 0, 0);
    doReq(0, OP_LD, 32'(LW * 4) + 32'h8, $urandom, 32'hCAFE_F00D, 1, 5, 0);
    doReq(0, OP_LD, 32'h17, 32'h0, 32'h0, 0, 0, 0);
    doReq(0, OP_LD, 32'(LW * 4) - 32'h1, 32'h0, 32'h0, 0, 0, 0);
    idle(0, 1);
    randomOps(0, 60);

    doReq(0, OP_LD, 32'h2000, 32'h0, 32'hAAAA_5555, 1, 6, 2);
    repeat (2) step();
    rstN[0] = 1'b1;
    idle(0, 3);
    doReq(0, OP_LD, 32'h14, 32'h0, 32'h0, 0, 0, 0);
    idle(0, 2);

    doReq(1, OP_ST, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    doReq(1, OP_LD, 32'h10, 32'h0, 32'h0, 0, 0, 0);
    for (int w = 0; w <= 16; w++) begin
      doReq(1, OP_ST, (w == 16) ? 32'(LW - 1) << 2 : 32'(w) << 2, $urandom, 32'h0, 0, 0, 0);
    end
    randomOps(1, 30);
    idle(1, 4);

    done = 1;
    for (int i = 0; i < 4 && !finalDone; i++) step();
    if (!finalDone) begin
      miscompares++;
      $display("FAIL final_check: monitor did not drain, required drain within 4 cycles");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
